// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posted-write buffer between the core data port and data memory. Stores are
//   queued in a small FIFO and drained over a req/ack write port. Loads read
//   memory combinationally and are checked against the pending stores.
//
//   Optional feature macro: STBUF_FWD_EN
//     defined   : a load that hits a pending store gets the youngest hit's data
//     undefined : a load that hits a pending store stalls until those stores drain
//
//   Ports
//     clk, reset          clock (rising edge), async active-low reset
//     memwrite, memread   core store / load request this cycle
//     aluout, writedata   core byte address (bits [1:0] ignored) / store data
//     readdata, stall     load data and core hold request (combinational)
//     flush_req           pulse: drain the buffer completely
//     flush_done          one-cycle pulse when the drain completes (registered)
//     mem_raddr, mem_rdata  combinational memory read port
//     mem_req, mem_addr, mem_wdata, mem_ack  memory write port (oldest entry)
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [AW-1:0] aluout,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  input  logic          flush_req,
  output logic          flush_done,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = AW - 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            flush_done_q, flush_done_d;

  logic [WW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;

  logic            full, empty, push, pop;
  logic            any_match, hazard;
`ifdef STBUF_FWD_EN
  logic [DW-1:0]   fwd_data;
`endif

  // FIFO status and write port, always presenting the oldest entry
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_req   = ~empty;
  assign mem_addr  = {addr_q[head_q], 2'b00};
  assign mem_wdata = data_q[head_q];
  assign mem_raddr = aluout;

  // ack outside a request is ignored; a stalled store is never pushed
  assign pop     = mem_req & mem_ack;
  assign push    = memwrite & ~stall;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Word-address match scan from head to tail so the last hit is the youngest
  always_comb begin : match_scan
    logic [PW-1:0] idx;
    idx       = '0;
    any_match = 1'b0;
`ifdef STBUF_FWD_EN
    fwd_data  = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == aluout[AW-1:2])) begin
        any_match = 1'b1;
`ifdef STBUF_FWD_EN
        fwd_data  = data_q[idx];
`endif
      end
    end
  end

`ifdef STBUF_FWD_EN
  assign hazard   = 1'b0;
  assign readdata = (memread && any_match) ? fwd_data : mem_rdata;
`else
  // hold the load until every matching store has left the buffer
  assign hazard   = memread & any_match;
  assign readdata = mem_rdata;
`endif

  assign stall = (memwrite & (full | (state_q == FLUSH))) | hazard;

  // Entry storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q]  <= aluout[AW-1:2];
        data_q[tail_q]  <= writedata;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Flush FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Flush completes on the edge where the buffer becomes (or already is) empty
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          if (count_d == '0) flush_done_d = 1'b1;
          else               state_d      = FLUSH;
        end
      end
      FLUSH: begin
        if (count_d == '0) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          memwrite = 1'b0, memread = 1'b0;
  logic [AW-1:0] aluout = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          stall;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .memwrite(memwrite), .memread(memread), .aluout(aluout), .writedata(writedata),
    .readdata(readdata), .stall(stall),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // memory read contents: a fixed function of the address
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
  endfunction

  assign mem_rdata = mem_model(mem_raddr);

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] wlog[$];
  bit          flushing = 1'b0;
  bit          exp_fd = 1'b0;
  int          fd_pulses = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core cycle: drive, check against the queue model at negedge, advance model
  task automatic cycle(input logic mw, input logic mr, input logic [31:0] a,
                       input logic [31:0] d, input logic ack, input logic fr);
    bit          exp_req, exp_stall, hit, do_pop, do_push;
    logic [31:0] hit_data, exp_rd;
    memwrite = mw; memread = mr; aluout = a; writedata = d; mem_ack = ack; flush_req = fr;
    @(negedge clk);
    exp_req  = (q.size() != 0);
    hit      = 1'b0;
    hit_data = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && q[i].a[31:2] == a[31:2]) begin
        hit      = 1'b1;
        hit_data = q[i].d;
      end
    end
`ifdef STBUF_FWD_EN
    exp_stall = mw && (q.size() == DEPTH || flushing);
    exp_rd    = (mr && hit) ? hit_data : mem_model(a);
`else
    exp_stall = (mw && (q.size() == DEPTH || flushing)) || (mr && hit);
    exp_rd    = mem_model(a);
`endif
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_wdata", mem_wdata, q[0].d);
    end
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("readdata", readdata, exp_rd);
    chk("mem_raddr", mem_raddr, a);
    chk("flush_done", 32'(flush_done), 32'(exp_fd));
    if (flush_done) fd_pulses++;
    do_pop  = exp_req && ack;
    do_push = mw && !exp_stall;
    if (do_pop) begin
      wlog.push_back(q[0].a);
      void'(q.pop_front());
    end
    if (do_push) q.push_back('{a: {a[31:2], 2'b00}, d: d});
    if (flushing || fr) begin
      if (q.size() == 0) begin
        flushing = 1'b0;
        exp_fd   = 1'b1;
      end else begin
        flushing = 1'b1;
        exp_fd   = 1'b0;
      end
    end else begin
      exp_fd = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ack, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, ack, 1'b0);
  endtask

  // Assert reset mid-cycle, check immediate effect, release after one edge
  task automatic mid_reset();
    #2;
    memwrite = 1'b0; memread = 1'b0; flush_req = 1'b0; mem_ack = 1'b0; aluout = 32'h0;
    reset = 1'b0;
    #1;
    chk("rst_mem_req_now", 32'(mem_req), 32'h0);
    chk("rst_flush_done_now", 32'(flush_done), 32'h0);
    chk("rst_stall_now", 32'(stall), 32'h0);
    q.delete();
    flushing = 1'b0;
    exp_fd   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_req_hold", 32'(mem_req), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    // 1: reset state
    aluout = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_mem_req", 32'(mem_req), 32'h0);
    chk("t1_stall", 32'(stall), 32'h0);
    chk("t1_flush_done", 32'(flush_done), 32'h0);
    chk("t1_readdata", readdata, mem_model(32'h0000_0040));
    reset = 1'b1;
    idle(1'b0, 2);

    // 2: single store with ack tied high
    wlog.delete();
    cycle(1'b1, 1'b0, 32'h10, 32'hAAAA_0001, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("t2_nwrites", 32'(wlog.size()), 32'd1);
    chk("t2_addr", wlog[0], 32'h10);

    // 3: fill with ack low, fifth store stalls until a slot frees
    wlog.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h10, 32'h3004, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h10, 32'h3004, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h10, 32'h3004, 1'b0, 1'b0);
    idle(1'b1, 6);
    chk("t3_nwrites", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t3_order", wlog[i], 32'(i * 4));

    // 4: load hitting two pending stores to the same word
    cycle(1'b1, 1'b0, 32'h20, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h20, 32'h2, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h22, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h22, 32'h0, 1'b1, 1'b0);
    idle(1'b1, 1);

    // 5: flush with three entries, ack every other cycle, stores held off
    fd_pulses = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h5000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h200, 32'h5555, 1'(i % 2), 1'b0);
    idle(1'b1, 3);
    chk("t5_fd_pulses", 32'(fd_pulses), 32'd1);

    // flush on an empty buffer completes on the next cycle
    fd_pulses = 0;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1'b0, 2);
    chk("empty_flush_pulses", 32'(fd_pulses), 32'd1);

    // 6: reset during a drain discards pending stores
    cycle(1'b1, 1'b0, 32'h300, 32'h6000, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h304, 32'h6001, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    wlog.delete();
    mid_reset();
    idle(1'b1, 4);
    chk("t6_no_writes", 32'(wlog.size()), 32'd0);

    // randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = {26'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      cycle(op < 4, (op >= 4) && (op < 7), a, $urandom, 1'($urandom), $urandom_range(0, 19) == 0);
    end
    idle(1'b1, 8);
    chk("final_empty", 32'(mem_req), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
